// File: rtl/notify_mwr_tx_if.sv
// -----------------------------------------------------------------------------
// notify_mwr_tx_if
//   Groups the 64-bit TRN transmit interface between a TLP source and the
//   PCIe endpoint block.
//
//   Signals (all active-low controls, TRN naming):
//     trn_td          64  TX data beat
//     trn_trem_n       8  remainder; 8'h00 = both DWs valid, 8'h0F = upper DW only
//     trn_tsof_n       1  start of frame
//     trn_teof_n       1  end of frame
//     trn_tsrc_rdy_n   1  source has a valid beat
//     trn_tsrc_dsc_n   1  source discontinue
//     trn_tdst_rdy_n   1  endpoint accepts the beat
//     trn_tdst_dsc_n   1  endpoint discontinues the frame
//     trn_tbuf_av      4  TX buffer availability per TLP class
//
//   Modports:
//     master - TLP source (drives data/control, observes endpoint status)
//     slave  - endpoint side
// -----------------------------------------------------------------------------
interface notify_mwr_tx_if;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic        trn_tdst_dsc_n;
    logic [3:0]  trn_tbuf_av;

    modport master (
        output trn_td,
        output trn_trem_n,
        output trn_tsof_n,
        output trn_teof_n,
        output trn_tsrc_rdy_n,
        output trn_tsrc_dsc_n,
        input  trn_tdst_rdy_n,
        input  trn_tdst_dsc_n,
        input  trn_tbuf_av
    );

    modport slave (
        input  trn_td,
        input  trn_trem_n,
        input  trn_tsof_n,
        input  trn_teof_n,
        input  trn_tsrc_rdy_n,
        input  trn_tsrc_dsc_n,
        output trn_tdst_rdy_n,
        output trn_tdst_dsc_n,
        output trn_tbuf_av
    );
endinterface

// File: rtl/notify_mwr_tx.sv
// -----------------------------------------------------------------------------
// notify_mwr_tx
//   On a user request, emits one posted 32-bit Memory Write TLP with a 1-DW
//   or 2-DW payload on the 64-bit TRN transmit interface. Used for host
//   status/notification writebacks.
//
//   Ports:
//     trn_clk              TRN clock, everything on the rising edge
//     reset                synchronous active-high reset
//     trn_lnk_up_n         link up (active-low); deasserted link acts as reset
//     cfg_completer_id     {bus,dev,func}, placed in the requester ID field
//     cfg_bus_mstr_enable  a TLP may only start while this is 1
//     notify_req           level request, sampled only while idle
//     notify_addr          host byte address (bits [1:0] ignored)
//     notify_data          payload: [31:0] first DW, [63:32] second DW
//     notify_two_dw        0: 1-DW payload, 1: 2-DW payload
//     notify_ack           one-cycle pulse when the TLP completed or aborted
//     notify_err           qualifies notify_ack: 1 = aborted by the endpoint
//     trn                  TRN TX bus (master side)
//
//   Frame layout (64-bit beats, upper DW first on the wire):
//     beat1: {hdr DW0, hdr DW1}              sof
//     beat2: {address, payload DW0}          eof when 1-DW
//     beat3: {payload DW1, 32'h0}, trem 0F   eof (2-DW only)
// -----------------------------------------------------------------------------
module notify_mwr_tx #(
    parameter logic [2:0] TC         = 3'b000,
    parameter int         BUF_AV_BIT = 1,
    parameter logic [7:0] TAG_INIT   = 8'h00
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic        trn_lnk_up_n,
    input  logic [15:0] cfg_completer_id,
    input  logic        cfg_bus_mstr_enable,
    input  logic        notify_req,
    input  logic [31:0] notify_addr,
    input  logic [63:0] notify_data,
    input  logic        notify_two_dw,
    output logic        notify_ack,
    output logic        notify_err,
    notify_mwr_tx_if.master trn
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT1 = 3'd1,
        ST_BEAT2 = 3'd2,
        ST_BEAT3 = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    state_t      state_reg;
    logic [7:0]  tag_reg;
    logic [29:0] addr_reg;
    logic [63:0] data_reg;
    logic        two_dw_reg;

    logic [63:0] td_reg;
    logic [7:0]  trem_n_reg;
    logic        tsof_n_reg;
    logic        teof_n_reg;
    logic        tsrc_rdy_n_reg;
    logic        ack_reg;
    logic        err_reg;

    logic        srst;
    logic        start;
    logic        in_beat;
    logic        abort;
    logic        xfer;
    logic        last_beat;
    logic        finish;
    logic [9:0]  hdr_length;
    logic [3:0]  hdr_last_be;
    logic [31:0] hdr_dw0;
    logic [31:0] hdr_dw1;

    // A dropped link behaves exactly like reset.
    assign srst  = reset | trn_lnk_up_n;

    assign start = notify_req & cfg_bus_mstr_enable & trn.trn_tbuf_av[BUF_AV_BIT];

    // Header is built from the live request inputs in the start cycle so beat1
    // can be presented on the very next cycle.
    assign hdr_length  = notify_two_dw ? 10'd2 : 10'd1;
    assign hdr_last_be = notify_two_dw ? 4'hF : 4'h0;
    assign hdr_dw0 = {1'b0, 7'b10_00000, 1'b0, TC, 4'b0000, 1'b0, 1'b0,
                      2'b00, 2'b00, hdr_length};
    assign hdr_dw1 = {cfg_completer_id, tag_reg, hdr_last_be, 4'hF};

    assign in_beat   = (state_reg == ST_BEAT1) || (state_reg == ST_BEAT2) ||
                       (state_reg == ST_BEAT3);
    // Endpoint discontinue wins over a simultaneous destination-ready.
    assign abort     = in_beat & ~trn.trn_tdst_dsc_n;
    assign xfer      = in_beat & trn.trn_tdst_dsc_n & ~tsrc_rdy_n_reg &
                       ~trn.trn_tdst_rdy_n;
    assign last_beat = (state_reg == ST_BEAT3) ||
                       ((state_reg == ST_BEAT2) && !two_dw_reg);
    assign finish    = xfer & last_beat;

    always_ff @(posedge trn_clk) begin
        if (srst) begin
            state_reg      <= ST_IDLE;
            tag_reg        <= TAG_INIT;
            addr_reg       <= '0;
            data_reg       <= '0;
            two_dw_reg     <= 1'b0;
            td_reg         <= '0;
            trem_n_reg     <= 8'h00;
            tsof_n_reg     <= 1'b1;
            teof_n_reg     <= 1'b1;
            tsrc_rdy_n_reg <= 1'b1;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg       <= notify_addr[31:2];
                        data_reg       <= notify_data;
                        two_dw_reg     <= notify_two_dw;
                        td_reg         <= {hdr_dw0, hdr_dw1};
                        trem_n_reg     <= 8'h00;
                        tsof_n_reg     <= 1'b0;
                        teof_n_reg     <= 1'b1;
                        tsrc_rdy_n_reg <= 1'b0;
                        state_reg      <= ST_BEAT1;
                    end
                end

                ST_BEAT1, ST_BEAT2, ST_BEAT3: begin
                    if (abort || finish) begin
                        // Frame over (normally or dropped): bus back to idle.
                        td_reg         <= '0;
                        trem_n_reg     <= 8'h00;
                        tsof_n_reg     <= 1'b1;
                        teof_n_reg     <= 1'b1;
                        tsrc_rdy_n_reg <= 1'b1;
                        ack_reg        <= 1'b1;
                        err_reg        <= abort;
                        state_reg      <= ST_ACK;
                        // An aborted TLP never reached the link, so its tag
                        // is reused by the next request.
                        if (!abort) begin
                            tag_reg <= tag_reg + 8'd1;
                        end
                    end else if (xfer) begin
                        if (state_reg == ST_BEAT1) begin
                            td_reg     <= {addr_reg, 2'b00, data_reg[31:0]};
                            trem_n_reg <= 8'h00;
                            tsof_n_reg <= 1'b0 ^ 1'b1;
                            teof_n_reg <= two_dw_reg;
                            state_reg  <= ST_BEAT2;
                        end else begin
                            td_reg     <= {data_reg[63:32], 32'h0000_0000};
                            trem_n_reg <= 8'h0F;
                            tsof_n_reg <= 1'b1;
                            teof_n_reg <= 1'b0;
                            state_reg  <= ST_BEAT3;
                        end
                    end
                    // No transfer: every beat output holds its value.
                end

                ST_ACK: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign trn.trn_td         = td_reg;
    assign trn.trn_trem_n     = trem_n_reg;
    assign trn.trn_tsof_n     = tsof_n_reg;
    assign trn.trn_teof_n     = teof_n_reg;
    assign trn.trn_tsrc_rdy_n = tsrc_rdy_n_reg;
    assign trn.trn_tsrc_dsc_n = 1'b1;
    assign notify_ack         = ack_reg;
    assign notify_err         = err_reg;

    // Address is DW aligned and only one buffer-available class matters.
    logic unused_ok;
    assign unused_ok = &{1'b0, notify_addr[1:0], trn.trn_tbuf_av};

endmodule

// File: doc/notify_mwr_tx.md
Name: notify_mwr_tx

Overview:
- TRN TX-side generator: on a user request, emits one posted 32-bit Memory Write TLP carrying 1 or 2 DW of payload to a host address.
- Outbound counterpart of the BAR2 RX decoder. Used for host status/notification writebacks (e.g. a status word after an interrupt-enable change).
- Sits between user logic and the 64-bit TRN transmit interface of the PCIe endpoint block. Sole TX source when instantiated.

Parameters:
- TC, 3'b000, traffic class placed in header DW0[22:20].
- BUF_AV_BIT, 1, index of trn_tbuf_av bit that flags posted-buffer availability.
- TAG_INIT, 8'h00, tag counter value after reset.

Ports:
- trn_clk  in  1  TRN clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- trn_lnk_up_n  in  1  link up, active-low; high acts exactly as reset.
- cfg_completer_id  in  16  {bus,dev,func}, used as requester ID.
- cfg_bus_mstr_enable  in  1  TLP start allowed only when 1.
- notify_req  in  1  level request; sampled only in IDLE.
- notify_addr  in  32  host byte address; bits[1:0] ignored.
- notify_data  in  64  payload; [31:0]=DW0, [63:32]=DW1.
- notify_two_dw  in  1  0: 1-DW payload, 1: 2-DW payload.
- notify_ack  out  1  one-cycle pulse: TLP completed or aborted.
- notify_err  out  1  valid with notify_ack; 1 = aborted by trn_tdst_dsc_n.
- trn_td  out  64  TX data.
- trn_trem_n  out  8  TX remainder, active-low.
- trn_tsof_n  out  1  start of frame, active-low.
- trn_teof_n  out  1  end of frame, active-low.
- trn_tsrc_rdy_n  out  1  source ready, active-low.
- trn_tsrc_dsc_n  out  1  source discontinue; tied high (never used).
- trn_tdst_rdy_n  in  1  destination ready, active-low.
- trn_tdst_dsc_n  in  1  destination discontinue, active-low.
- trn_tbuf_av  in  4  TX buffer availability.

Behaviour:
- Reset (reset=1 or trn_lnk_up_n=1, synchronous):
  - State IDLE; tag=TAG_INIT.
  - trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n and trn_tsrc_dsc_n =1.
  - trn_td=0; trn_trem_n=8'h00.
  - notify_ack=0, notify_err=0.
  - A pending request is dropped without ack.
- States: IDLE, BEAT1, BEAT2, BEAT3, ACK. All outputs registered.
- IDLE:
  - Start when notify_req=1, cfg_bus_mstr_enable=1 and trn_tbuf_av[BUF_AV_BIT]=1.
  - On start, capture addr, data and two_dw, then go to BEAT1.
  - Otherwise stay in IDLE with outputs idle.
- BEAT1:
  - tsof_n=0, tsrc_rdy_n=0, trem_n=8'h00.
  - td[63:32]=DW0 = {1'b0, 7'b10_00000, 1'b0, TC, 4'b0, TD=0, EP=0, attr=2'b00, 2'b00, length}, where length=10'd1 or 10'd2.
  - td[31:0]=DW1 = {cfg_completer_id, tag, lastBE, 4'hF}, where lastBE=4'h0 (1 DW) or 4'hF (2 DW).
- BEAT2:
  - td[63:32]={addr[31:2],2'b00}; td[31:0]=data[31:0]; trem_n=8'h00.
  - teof_n=0 when 1-DW.
- BEAT3 (2-DW only):
  - td[63:32]=data[63:32]; td[31:0]=0; trem_n=8'h0F; teof_n=0.
- Beat handshake:
  - A beat transfers on a cycle with tsrc_rdy_n=0 and tdst_rdy_n=0.
  - Until then, td, trem_n, tsof_n and teof_n are held unchanged.
  - tsrc_rdy_n stays 0 continuously from BEAT1 to the final beat (no bubbles).
  - After the final beat transfers: tsrc_rdy_n=1, tag<=tag+1 (wraps 8'hFF→8'h00), go to ACK.
- ACK: notify_ack=1 for one cycle, then IDLE. A new TLP can start one cycle after ACK at the earliest. A still-high notify_req starts another TLP.
- Discontinue: trn_tdst_dsc_n=0 in any of BEAT1..BEAT3:
  - Drop the frame next cycle (tsrc_rdy_n=1, tsof_n and teof_n =1).
  - Go to ACK with notify_err=1; tag is not incremented.
  - tdst_dsc_n takes priority over a simultaneous tdst_rdy_n=0.
- Start conditions are sampled only in IDLE. Deassertion of bus master enable or tbuf_av mid-TLP does not affect the frame.
- Addresses ≥4 GB are unsupported (MWr32 only).

Test Plan:
- 1-DW write: addr=32'h1234_5678, data=64'h0000_0000_CAFE_BABE, id=16'h0100, tdst_rdy_n=0 -> beat1 td=64'h4000_0001_0100_000F with sof; beat2 td=64'h1234_5678_CAFE_BABE with eof, trem_n=8'h00; ack 1 cycle later, err=0.
- 2-DW write: data=64'h1111_2222_3333_4444, two_dw=1 -> length=2, DW1[7:0]=8'hFF; beat2 td[31:0]=32'h3333_4444; beat3 td=64'h1111_2222_0000_0000, trem_n=8'h0F, eof.
- Back-pressure: tdst_rdy_n=1 for 3 cycles during beat2 -> td, eof and tsrc_rdy_n held stable; TLP completes normally when tdst_rdy_n=0.
- Gating: cfg_bus_mstr_enable=0 or trn_tbuf_av[1]=0 with req=1 -> no sof for 20 cycles; enabling it -> TLP starts.
- Discontinue: tdst_dsc_n=0 during beat2 -> tsrc_rdy_n=1 next cycle; ack with err=1; next TLP reuses the same tag.
- Tag wrap and reset: 256 back-to-back TLPs -> tags 00..FF then 00; reset (or trn_lnk_up_n=1) asserted in beat2 -> outputs idle next cycle, no ack, tag=TAG_INIT.
